// File: rtl/tlul_snoop_pkg.sv
// Shared types, constants and address-window helper for the TL-UL write snoop.
// The event timestamp field exists only when TLUL_WRITE_SNOOP_TIMESTAMP_EN is defined.
package tlul_snoop_pkg;

  localparam int unsigned DefaultDepth = 8;
  localparam int unsigned TsW          = 32;

  localparam logic [2:0] PutFullData    = 3'h0;
  localparam logic [2:0] PutPartialData = 3'h1;
  localparam logic [2:0] Get            = 3'h4;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

  typedef struct packed {
    logic [31:0]    addr;
    logic [31:0]    data;
    logic [3:0]     mask;
`ifdef TLUL_WRITE_SNOOP_TIMESTAMP_EN
    logic [TsW-1:0] ts;
`endif
  } snoop_evt_t;

  function automatic logic addr_hit(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [31:0] mask);
    return (addr & mask) == (base & mask);
  endfunction

endpackage

// File: rtl/tlul_snoop_rr_arb.sv
// Round-robin arbiter: grants one requester per advancing cycle, pointer moves past the winner.
module tlul_snoop_rr_arb #(
  parameter int unsigned N = 2,
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [N-1:0]    req,
  input  logic            advance,
  output logic [N-1:0]    gnt,
  output logic [IdxW-1:0] gnt_idx
);

  logic [IdxW-1:0] ptr;
  logic [IdxW-1:0] idx;
  logic            found;

  // first requester at or after the pointer wins
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = IdxW'((32'(ptr) + k) % N);
      if (advance && !found && req[idx]) begin
        found      = 1'b1;
        gnt[idx]   = 1'b1;
        gnt_idx    = idx;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (gnt_idx == IdxW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/tlul_write_snoop.sv
// Passive multi-channel TL-UL Put monitor feeding a first-word-fall-through event FIFO.
// Define TLUL_WRITE_SNOOP_TIMESTAMP_EN to stamp events with a free-running cycle count.
module tlul_write_snoop
  import tlul_snoop_pkg::*;
#(
  parameter int unsigned NumCh    = 2,
  parameter int unsigned Depth    = DefaultDepth,
  parameter logic [NumCh-1:0][31:0] MatchBase = {NumCh{32'h0}},
  parameter logic [NumCh-1:0][31:0] MatchMask = {NumCh{32'hFFFF_FFFF}},
  parameter int unsigned DropCntW = 16,
  localparam int unsigned ChW  = (NumCh > 1) ? $clog2(NumCh) : 1,
  localparam int unsigned LvlW = $clog2(Depth) + 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  tl_h2d_t [NumCh-1:0]    tl_h2d_i,
  input  tl_d2h_t [NumCh-1:0]    tl_d2h_i,
  input  logic [NumCh-1:0]       ch_en_i,
  output logic                   evt_valid_o,
  input  logic                   evt_ready_i,
  output logic [ChW-1:0]         evt_ch_o,
  output logic [31:0]            evt_addr_o,
  output logic [31:0]            evt_data_o,
  output logic [3:0]             evt_mask_o,
`ifdef TLUL_WRITE_SNOOP_TIMESTAMP_EN
  output logic [TsW-1:0]         evt_ts_o,
`endif
  output logic [LvlW-1:0]        fifo_level_o,
  output logic [DropCntW-1:0]    drop_cnt_o,
  input  logic                   clr_drop_i
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned SumW = DropCntW + 4;

  logic [NumCh-1:0]       capture, skid_vld, gnt, drop;
  snoop_evt_t [NumCh-1:0] cap_evt, skid_q;
  logic [ChW-1:0]         gnt_idx;
  logic                   pop, push, advance;
  logic [3:0]             n_drop;
  logic [SumW-1:0]        drop_sum;
  snoop_evt_t             push_evt, head_evt;
  logic [ChW-1:0]         head_ch;
  logic [PtrW-1:0]        wr_ptr, rd_ptr, rd_ptr_n;
  logic [LvlW-1:0]        remain, level_n;
  snoop_evt_t             mem    [Depth];
  logic [ChW-1:0]         mem_ch [Depth];
  logic                   unused_tl;

  assign unused_tl = ^{tl_h2d_i, tl_d2h_i};

`ifdef TLUL_WRITE_SNOOP_TIMESTAMP_EN
  logic [TsW-1:0] ts_cnt;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) ts_cnt <= '0;
    else         ts_cnt <= ts_cnt + 1'b1;
  end
`endif

  // accepted Put inside the channel's window
  always_comb begin
    capture = '0;
    cap_evt = '0;
    for (int unsigned i = 0; i < NumCh; i++) begin
      capture[i] = tl_h2d_i[i].a_valid & tl_d2h_i[i].a_ready & ch_en_i[i]
                 & ((tl_h2d_i[i].a_opcode == PutFullData) |
                    (tl_h2d_i[i].a_opcode == PutPartialData))
                 & addr_hit(tl_h2d_i[i].a_address, MatchBase[i], MatchMask[i]);
      cap_evt[i].addr = tl_h2d_i[i].a_address;
      cap_evt[i].data = tl_h2d_i[i].a_data;
      cap_evt[i].mask = tl_h2d_i[i].a_mask;
`ifdef TLUL_WRITE_SNOOP_TIMESTAMP_EN
      cap_evt[i].ts   = ts_cnt;
`endif
    end
  end

  assign drop = capture & skid_vld & ~gnt;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      skid_vld <= '0;
      skid_q   <= '0;
    end else begin
      for (int unsigned i = 0; i < NumCh; i++) begin
        if (capture[i] && (!skid_vld[i] || gnt[i])) begin
          skid_vld[i] <= 1'b1;
          skid_q[i]   <= cap_evt[i];
        end else if (gnt[i]) begin
          skid_vld[i] <= 1'b0;
        end
      end
    end
  end

  assign pop     = evt_valid_o & evt_ready_i;
  assign advance = (fifo_level_o != LvlW'(Depth)) | pop;
  assign push    = |gnt;

  tlul_snoop_rr_arb #(.N(NumCh)) u_arb (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .req     (skid_vld),
    .advance (advance),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // several channels may drop in the same cycle; count saturates
  always_comb begin
    n_drop = '0;
    for (int unsigned i = 0; i < NumCh; i++) begin
      n_drop = n_drop + 4'(drop[i]);
    end
    drop_sum = SumW'(drop_cnt_o) + SumW'(n_drop);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_drop_i)          drop_cnt_o <= '0;
    else if (|drop_sum[SumW-1:DropCntW]) drop_cnt_o <= '1;
    else                                 drop_cnt_o <= drop_sum[DropCntW-1:0];
  end

  assign push_evt = skid_q[gnt_idx];
  assign remain   = fifo_level_o - LvlW'(pop);
  assign level_n  = remain + LvlW'(push);
  assign rd_ptr_n = rd_ptr + PtrW'(pop);

  // next head: the incoming entry when nothing else remains, else the stored successor
  always_comb begin
    head_evt = mem[rd_ptr_n];
    head_ch  = mem_ch[rd_ptr_n];
    if (remain == '0) begin
      head_evt = push_evt;
      head_ch  = gnt_idx;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr]    <= push_evt;
      mem_ch[wr_ptr] <= gnt_idx;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_level_o <= '0;
      evt_valid_o  <= 1'b0;
      evt_ch_o     <= '0;
      evt_addr_o   <= '0;
      evt_data_o   <= '0;
      evt_mask_o   <= '0;
`ifdef TLUL_WRITE_SNOOP_TIMESTAMP_EN
      evt_ts_o     <= '0;
`endif
    end else begin
      wr_ptr       <= wr_ptr + PtrW'(push);
      rd_ptr       <= rd_ptr_n;
      fifo_level_o <= level_n;
      evt_valid_o  <= (level_n != '0);
      if (level_n != '0) begin
        evt_ch_o   <= head_ch;
        evt_addr_o <= head_evt.addr;
        evt_data_o <= head_evt.data;
        evt_mask_o <= head_evt.mask;
`ifdef TLUL_WRITE_SNOOP_TIMESTAMP_EN
        evt_ts_o   <= head_evt.ts;
`endif
      end
    end
  end

endmodule

// File: tb/tb_tlul_write_snoop.sv
// Bench for tlul_write_snoop: directed scenarios plus randomized traffic against a queue-based model.
// Timestamp checks are compiled in when TLUL_WRITE_SNOOP_TIMESTAMP_EN is defined.
`timescale 1ns/1ps
module tb_tlul_write_snoop;
  import tlul_snoop_pkg::*;

  localparam int unsigned NCH   = 2;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] BASE0 = 32'h2000_0000, MASK0 = 32'hFFFF_F000;
  localparam logic [31:0] BASE1 = 32'h3000_0000, MASK1 = 32'hFFFF_0000;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  tl_h2d_t [1:0]   h2d;
  tl_d2h_t [1:0]   d2h;
  logic [1:0]      ch_en;
  logic            evt_valid, evt_ready, clr_drop;
  logic [0:0]      evt_ch;
  logic [31:0]     evt_addr, evt_data;
  logic [3:0]      evt_mask;
  logic [2:0]      fifo_level;
  logic [15:0]     drop_cnt;
`ifdef TLUL_WRITE_SNOOP_TIMESTAMP_EN
  logic [31:0]     evt_ts;
`endif

  int checks = 0;
  int passed = 0;

  typedef struct {
    int          ch;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
    logic [31:0] ts;
  } mev_t;

  logic [31:0] mbase [2] = '{BASE0, BASE1};
  logic [31:0] mmask [2] = '{MASK0, MASK1};
  mev_t        fifo_q [$];
  mev_t        mskid [2];
  bit          mskid_v [2];
  mev_t        last_head;
  int          rr;
  int          mdrop;
  logic [31:0] mts;

  always #5 clk = ~clk;

  tlul_write_snoop #(
    .NumCh    (NCH),
    .Depth    (DEPTH),
    .MatchBase({BASE1, BASE0}),
    .MatchMask({MASK1, MASK0}),
    .DropCntW (16)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .tl_h2d_i     (h2d),
    .tl_d2h_i     (d2h),
    .ch_en_i      (ch_en),
    .evt_valid_o  (evt_valid),
    .evt_ready_i  (evt_ready),
    .evt_ch_o     (evt_ch),
    .evt_addr_o   (evt_addr),
    .evt_data_o   (evt_data),
    .evt_mask_o   (evt_mask),
`ifdef TLUL_WRITE_SNOOP_TIMESTAMP_EN
    .evt_ts_o     (evt_ts),
`endif
    .fifo_level_o (fifo_level),
    .drop_cnt_o   (drop_cnt),
    .clr_drop_i   (clr_drop)
  );

  // reference: one Put per channel lands in a one-deep holding slot, slots drain round-robin into a queue
  task automatic model_step();
    mev_t gev;
    int   g;
    int   nd;
    bit   pop;
    bit   hit;
    if (!rst_n) begin
      fifo_q.delete();
      mskid_v[0] = 0;
      mskid_v[1] = 0;
      rr = 0;
      mdrop = 0;
      mts = '0;
      last_head = '{default: 0};
      return;
    end
    pop = (fifo_q.size() > 0) && evt_ready;
    g = -1;
    if (fifo_q.size() < DEPTH || pop) begin
      for (int k = 0; k < NCH; k++) begin
        int c = (rr + k) % NCH;
        if (g < 0 && mskid_v[c]) g = c;
      end
    end
    if (g >= 0) begin
      gev = mskid[g];
      mskid_v[g] = 0;
      rr = (g + 1) % NCH;
    end
    nd = 0;
    for (int c = 0; c < NCH; c++) begin
      hit = h2d[c].a_valid && d2h[c].a_ready && ch_en[c] &&
            (h2d[c].a_opcode == PutFullData || h2d[c].a_opcode == PutPartialData) &&
            ((h2d[c].a_address & mmask[c]) == (mbase[c] & mmask[c]));
      if (hit) begin
        if (mskid_v[c]) nd++;
        else begin
          mskid_v[c] = 1;
          mskid[c] = '{ch: c, addr: h2d[c].a_address, data: h2d[c].a_data,
                       mask: h2d[c].a_mask, ts: mts};
        end
      end
    end
    if (pop) void'(fifo_q.pop_front());
    if (g >= 0) fifo_q.push_back(gev);
    if (clr_drop) mdrop = 0;
    else mdrop = (mdrop + nd > 65535) ? 65535 : mdrop + nd;
    mts = mts + 32'd1;
    if (fifo_q.size() > 0) last_head = fifo_q[0];
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_all();
    for (int c = 0; c < NCH; c++) begin
      h2d[c] = '0;
      d2h[c] = '0;
      d2h[c].a_ready = 1'b1;
    end
    ch_en = 2'b11;
  endtask

  task automatic drive_put(input int c, input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] mask);
    h2d[c].a_valid   = 1'b1;
    h2d[c].a_opcode  = op;
    h2d[c].a_address = addr;
    h2d[c].a_data    = data;
    h2d[c].a_mask    = mask;
    h2d[c].a_size    = 2'd2;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_all();
    evt_ready = 1'b0;
    clr_drop = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    checks++; if (evt_valid !== 1'b0) $display("FAIL reset_valid got=%0b exp=0", evt_valid); else passed++;
    checks++; if (fifo_level !== 3'd0) $display("FAIL reset_level got=%0d exp=0", fifo_level); else passed++;
    checks++; if (drop_cnt !== 16'd0) $display("FAIL reset_drop got=%0d exp=0", drop_cnt); else passed++;
    checks++; if ({evt_ch, evt_addr, evt_data, evt_mask} !== 69'd0)
      $display("FAIL reset_data got=%h/%h/%h/%h exp=0", evt_ch, evt_addr, evt_data, evt_mask); else passed++;
    tick();
  endtask

  task automatic test_window_hit();
    drive_put(0, PutFullData, 32'h2000_001c, 32'h41, 4'hF);
    tick();
    idle_all();
    checks++; if (evt_valid !== 1'b0) $display("FAIL hit_early got=%0b exp=0", evt_valid); else passed++;
    tick();
    checks++; if (evt_valid !== 1'b1) $display("FAIL hit_valid got=%0b exp=1", evt_valid); else passed++;
    checks++; if ({evt_ch, evt_addr, evt_data, evt_mask} !== {1'b0, 32'h2000_001c, 32'h41, 4'hF})
      $display("FAIL hit_data got=%h/%h/%h/%h exp=0/2000001c/41/f", evt_ch, evt_addr, evt_data, evt_mask); else passed++;
    checks++; if (fifo_level !== 3'd1) $display("FAIL hit_level got=%0d exp=1", fifo_level); else passed++;
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    checks++; if (evt_valid !== 1'b0) $display("FAIL hit_popped got=%0b exp=0", evt_valid); else passed++;
    checks++; if (evt_data !== 32'h41) $display("FAIL hit_hold got=%h exp=41", evt_data); else passed++;
  endtask

  task automatic test_filtering();
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: drive_put(0, Get, 32'h2000_001c, 32'h55, 4'hF);
        1: drive_put(0, PutFullData, 32'h1000_0000, 32'h55, 4'hF);
        2: begin drive_put(0, PutFullData, 32'h2000_001c, 32'h55, 4'hF); ch_en[0] = 1'b0; end
        default: begin drive_put(0, PutPartialData, 32'h2000_001c, 32'h55, 4'h1); d2h[0].a_ready = 1'b0; end
      endcase
      tick();
      idle_all();
      tick();
      tick();
      tick();
      checks++; if (evt_valid !== 1'b0) $display("FAIL filter%0d_valid got=%0b exp=0", k, evt_valid); else passed++;
      checks++; if (drop_cnt !== 16'd0) $display("FAIL filter%0d_drop got=%0d exp=0", k, drop_cnt); else passed++;
    end
  endtask

  task automatic test_simultaneous();
    pulse_reset();
    evt_ready = 1'b1;
    drive_put(0, PutFullData, 32'h2000_0004, 32'hA0, 4'hF);
    drive_put(1, PutPartialData, 32'h3000_0010, 32'hB1, 4'h3);
    tick();
    idle_all();
    checks++; if (evt_valid !== 1'b0) $display("FAIL simul_early got=%0b exp=0", evt_valid); else passed++;
    tick();
    checks++; if ({evt_valid, evt_ch, evt_data} !== {1'b1, 1'b0, 32'hA0})
      $display("FAIL simul_first got=%0b/%0d/%h exp=1/0/a0", evt_valid, evt_ch, evt_data); else passed++;
    tick();
    checks++; if ({evt_valid, evt_ch, evt_addr, evt_data, evt_mask} !== {1'b1, 1'b1, 32'h3000_0010, 32'hB1, 4'h3})
      $display("FAIL simul_second got=%0b/%0d/%h/%h/%h exp=1/1/30000010/b1/3", evt_valid, evt_ch, evt_addr, evt_data, evt_mask); else passed++;
    tick();
    checks++; if (evt_valid !== 1'b0) $display("FAIL simul_drained got=%0b exp=0", evt_valid); else passed++;
    evt_ready = 1'b0;
  endtask

  task automatic test_overflow();
    logic [31:0] got [$];
    pulse_reset();
    evt_ready = 1'b0;
    for (int d = 1; d <= 6; d++) begin
      drive_put(0, PutFullData, 32'h2000_0100, 32'(d), 4'hF);
      tick();
    end
    idle_all();
    tick();
    checks++; if (fifo_level !== 3'd4) $display("FAIL ovf_level got=%0d exp=4", fifo_level); else passed++;
    checks++; if (drop_cnt !== 16'd1) $display("FAIL ovf_drop got=%0d exp=1", drop_cnt); else passed++;
    checks++; if ({evt_valid, evt_data} !== {1'b1, 32'd1})
      $display("FAIL ovf_head got=%0b/%0d exp=1/1", evt_valid, evt_data); else passed++;
    evt_ready = 1'b1;
    for (int n = 0; n < 12; n++) begin
      if (evt_valid) got.push_back(evt_data);
      tick();
    end
    evt_ready = 1'b0;
    checks++; if (got.size() !== 5) $display("FAIL ovf_count got=%0d exp=5", got.size()); else passed++;
    for (int k = 0; k < got.size() && k < 5; k++) begin
      checks++; if (got[k] !== 32'(k + 1)) $display("FAIL ovf_order%0d got=%0d exp=%0d", k, got[k], k + 1); else passed++;
    end
    checks++; if (drop_cnt !== 16'd1) $display("FAIL ovf_drop_hold got=%0d exp=1", drop_cnt); else passed++;
  endtask

  task automatic test_reset_mid();
    evt_ready = 1'b0;
    for (int d = 0; d < 3; d++) begin
      drive_put(0, PutFullData, 32'h2000_0040, 32'h11 + 32'(d), 4'hF);
      tick();
    end
    idle_all();
    tick();
    tick();
    checks++; if (fifo_level !== 3'd3) $display("FAIL mid_level_before got=%0d exp=3", fifo_level); else passed++;
    pulse_reset();
    checks++; if (evt_valid !== 1'b0) $display("FAIL mid_valid got=%0b exp=0", evt_valid); else passed++;
    checks++; if (fifo_level !== 3'd0) $display("FAIL mid_level got=%0d exp=0", fifo_level); else passed++;
    checks++; if (drop_cnt !== 16'd0) $display("FAIL mid_drop got=%0d exp=0", drop_cnt); else passed++;
    drive_put(0, PutPartialData, 32'h2000_0200, 32'h99, 4'h3);
    tick();
    idle_all();
    tick();
    checks++; if ({evt_valid, evt_addr, evt_data, evt_mask} !== {1'b1, 32'h2000_0200, 32'h99, 4'h3})
      $display("FAIL mid_after got=%0b/%h/%h/%h exp=1/20000200/99/3", evt_valid, evt_addr, evt_data, evt_mask); else passed++;
  endtask

  task automatic test_random();
    mev_t        e;
    logic [31:0] a;
    int          r;
    pulse_reset();
    for (int n = 0; n < 600; n++) begin
      for (int c = 0; c < NCH; c++) begin
        h2d[c].a_valid = ($urandom_range(0, 3) != 0);
        r = $urandom_range(0, 5);
        h2d[c].a_opcode = (r < 3) ? PutFullData : (r < 5) ? PutPartialData : Get;
        a = $urandom();
        if ($urandom_range(0, 3) != 0) a = (mbase[c] & mmask[c]) | (a & ~mmask[c]);
        h2d[c].a_address = a;
        h2d[c].a_data = $urandom();
        h2d[c].a_mask = 4'($urandom_range(0, 15));
        d2h[c].a_ready = ($urandom_range(0, 4) != 0);
        ch_en[c] = ($urandom_range(0, 7) != 0);
      end
      evt_ready = (n < 300) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 5) != 0);
      clr_drop = ($urandom_range(0, 40) == 0);
      tick();
      e = (fifo_q.size() > 0) ? fifo_q[0] : last_head;
      checks++; if (evt_valid !== (fifo_q.size() > 0))
        $display("FAIL rnd_valid cyc=%0d got=%0b exp=%0b", n, evt_valid, fifo_q.size() > 0); else passed++;
      checks++; if (fifo_level !== 3'(fifo_q.size()))
        $display("FAIL rnd_level cyc=%0d got=%0d exp=%0d", n, fifo_level, fifo_q.size()); else passed++;
      checks++; if (drop_cnt !== 16'(mdrop))
        $display("FAIL rnd_drop cyc=%0d got=%0d exp=%0d", n, drop_cnt, mdrop); else passed++;
      checks++; if ({evt_ch, evt_addr, evt_data, evt_mask} !== {1'(e.ch), e.addr, e.data, e.mask})
        $display("FAIL rnd_data cyc=%0d got=%0d/%h/%h/%h exp=%0d/%h/%h/%h", n, evt_ch, evt_addr, evt_data,
                 evt_mask, e.ch, e.addr, e.data, e.mask); else passed++;
`ifdef TLUL_WRITE_SNOOP_TIMESTAMP_EN
      checks++; if (evt_ts !== e.ts) $display("FAIL rnd_ts cyc=%0d got=%0d exp=%0d", n, evt_ts, e.ts); else passed++;
`endif
    end
    idle_all();
    clr_drop = 1'b0;
    evt_ready = 1'b1;
    for (int n = 0; n < 12; n++) tick();
    checks++; if ({evt_valid, fifo_level} !== {1'b0, 3'd0})
      $display("FAIL rnd_drain got=%0b/%0d exp=0/0", evt_valid, fifo_level); else passed++;
  endtask

  initial begin
    idle_all();
    evt_ready = 1'b0;
    clr_drop = 1'b0;
    test_reset();
    test_window_hit();
    test_filtering();
    test_simultaneous();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
